pifo_bypass_dispatcher: RTL and testbench

Sits directly downstream of `output_queue_bypass_checker` in the PIFO root scheduler. It re-aligns each PIFO info word with the checker's one-bit bypass verdict and steers the word to one of two buffered outputs. Bypassed entries go to the egress path. All other entries go to the calendar enqueue path. Each path has a small FIFO so downstream back-pressure is absorbed without stalling the handshake-free checker. Entries that cannot be buffered are dropped and counted.

---
 rtl/pifo_sched_pkg.sv | 17 +
 rtl/dispatch_fifo.sv | 60 ++++++
 rtl/pifo_bypass_dispatcher.sv | 112 +++++++++++
 tb/tb_pifo_bypass_dispatcher.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pifo_sched_pkg.sv
// Shared definitions for the PIFO root scheduler blocks: default word width,
// the tagged info word layout and the FIFO pointer-width helper.
package pifo_sched_pkg;

  localparam int DEFAULT_PIFO_INFO_WIDTH = 32;

  typedef struct packed {
    logic                               tag_valid;
    logic [DEFAULT_PIFO_INFO_WIDTH-1:0] info;
  } pifo_info_t;

  // A depth-1 FIFO would still need a one-bit pointer to be well formed.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Small register FIFO with a write-side full flag; output valid and data come
// only from stored state, so ready never reaches them combinationally.
module dispatch_fifo
  import pifo_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_PIFO_INFO_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             m_axis_valid,
  output logic [WIDTH-1:0] m_axis_data,
  input  logic             m_axis_ready
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             push;
  logic             pop;

  // A full FIFO still takes a write when its head leaves in the same cycle.
  assign pop          = m_axis_valid && m_axis_ready;
  assign full         = (count == FULL_COUNT);
  assign push         = wr_valid && (!full || pop);
  assign m_axis_valid = (count != '0);
  assign m_axis_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pifo_bypass_dispatcher.sv
// Re-aligns PIFO info words with the bypass checker's delayed verdict and
// steers each word into the egress (bypass) or calendar FIFO.
module pifo_bypass_dispatcher
  import pifo_sched_pkg::*;
#(
  parameter int PIFO_INFO_WIDTH = DEFAULT_PIFO_INFO_WIDTH,
  parameter int CHECK_LATENCY   = 1,
  parameter int FIFO_DEPTH      = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       s_axis_valid,
  input  logic [PIFO_INFO_WIDTH-1:0] s_axis_pifo_info,
  input  logic                       s_axis_check_valid,
  input  logic                       s_axis_bypass_en,
  output logic                       m_axis_bypass_valid,
  output logic [PIFO_INFO_WIDTH-1:0] m_axis_bypass_data,
  input  logic                       m_axis_bypass_ready,
  output logic                       m_axis_cal_valid,
  output logic [PIFO_INFO_WIDTH-1:0] m_axis_cal_data,
  input  logic                       m_axis_cal_ready,
  output logic [CNT_WIDTH-1:0]       drop_cnt,
  output logic                       err_align
);

  localparam int LAST = CHECK_LATENCY - 1;

  logic [CHECK_LATENCY-1:0]   tag_q;
  logic [PIFO_INFO_WIDTH-1:0] info_q [CHECK_LATENCY];

  logic dispatch;
  logic misalign;
  logic byp_wr;
  logic cal_wr;
  logic byp_full;
  logic cal_full;
  logic byp_pop;
  logic cal_pop;
  logic drop;

  // Free-running delay line matching the checker's pipeline depth.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_q <= '0;
      for (int i = 0; i < CHECK_LATENCY; i++) begin
        info_q[i] <= '0;
      end
    end else begin
      tag_q[0]  <= s_axis_valid;
      info_q[0] <= s_axis_pifo_info;
      for (int i = 1; i < CHECK_LATENCY; i++) begin
        tag_q[i]  <= tag_q[i-1];
        info_q[i] <= info_q[i-1];
      end
    end
  end

  assign dispatch = tag_q[LAST] && s_axis_check_valid;
  assign misalign = tag_q[LAST] ^ s_axis_check_valid;
  assign byp_wr   = dispatch && s_axis_bypass_en;
  assign cal_wr   = dispatch && !s_axis_bypass_en;
  assign byp_pop  = m_axis_bypass_valid && m_axis_bypass_ready;
  assign cal_pop  = m_axis_cal_valid && m_axis_cal_ready;
  assign drop     = (byp_wr && byp_full && !byp_pop) ||
                    (cal_wr && cal_full && !cal_pop);

  dispatch_fifo #(
    .WIDTH (PIFO_INFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_bypass_fifo (
    .clk          (clk),
    .rstn         (rstn),
    .wr_valid     (byp_wr),
    .wr_data      (info_q[LAST]),
    .full         (byp_full),
    .m_axis_valid (m_axis_bypass_valid),
    .m_axis_data  (m_axis_bypass_data),
    .m_axis_ready (m_axis_bypass_ready)
  );

  dispatch_fifo #(
    .WIDTH (PIFO_INFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_cal_fifo (
    .clk          (clk),
    .rstn         (rstn),
    .wr_valid     (cal_wr),
    .wr_data      (info_q[LAST]),
    .full         (cal_full),
    .m_axis_valid (m_axis_cal_valid),
    .m_axis_data  (m_axis_cal_data),
    .m_axis_ready (m_axis_cal_ready)
  );

  // Misaligned slots are discarded silently apart from the sticky flag;
  // only genuine buffer overflows count as drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt  <= '0;
      err_align <= 1'b0;
    end else begin
      if (drop && (drop_cnt != {CNT_WIDTH{1'b1}})) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
      if (misalign) begin
        err_align <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pifo_bypass_dispatcher.sv
// Directed self-checking bench for pifo_bypass_dispatcher (CHECK_LATENCY=1, depth 4).
module tb_pifo_bypass_dispatcher;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_axis_valid;
  logic [31:0] s_axis_pifo_info;
  logic        s_axis_check_valid;
  logic        s_axis_bypass_en;
  logic        m_axis_bypass_valid;
  logic [31:0] m_axis_bypass_data;
  logic        m_axis_bypass_ready;
  logic        m_axis_cal_valid;
  logic [31:0] m_axis_cal_data;
  logic        m_axis_cal_ready;
  logic [15:0] drop_cnt;
  logic        err_align;

  int checks   = 0;
  int failures = 0;

  pifo_bypass_dispatcher #(
    .PIFO_INFO_WIDTH (32),
    .CHECK_LATENCY   (1),
    .FIFO_DEPTH      (4),
    .CNT_WIDTH       (16)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .s_axis_valid        (s_axis_valid),
    .s_axis_pifo_info    (s_axis_pifo_info),
    .s_axis_check_valid  (s_axis_check_valid),
    .s_axis_bypass_en    (s_axis_bypass_en),
    .m_axis_bypass_valid (m_axis_bypass_valid),
    .m_axis_bypass_data  (m_axis_bypass_data),
    .m_axis_bypass_ready (m_axis_bypass_ready),
    .m_axis_cal_valid    (m_axis_cal_valid),
    .m_axis_cal_data     (m_axis_cal_data),
    .m_axis_cal_ready    (m_axis_cal_ready),
    .drop_cnt            (drop_cnt),
    .err_align           (err_align)
  );

  always #5 clk = ~clk;

  // Drives one cycle of input/checker-verdict stimulus, then lands 1 time unit past the edge.
  task automatic apply_stimulus(input logic v, input logic [31:0] info,
                                input logic cv, input logic be);
    s_axis_valid       = v;
    s_axis_pifo_info   = info;
    s_axis_check_valid = cv;
    s_axis_bypass_en   = be;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (m_axis_bypass_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_byp_valid got %b want 0", m_axis_bypass_valid); end
    checks++; if (m_axis_cal_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_cal_valid got %b want 0", m_axis_cal_valid); end
    checks++; if (m_axis_bypass_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_byp_data got %h want 0", m_axis_bypass_data); end
    checks++; if (m_axis_cal_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_cal_data got %h want 0", m_axis_cal_data); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    checks++; if (err_align !== 1'b0) begin failures++; $display("[TB] FAIL reset_err_align got %b want 0", err_align); end
  endtask

  task automatic test_bypass_path();
    m_axis_bypass_ready = 1'b1;
    m_axis_cal_ready    = 1'b1;
    apply_stimulus(1'b1, 32'h0000_0010, 1'b0, 1'b0);
    checks++; if (m_axis_bypass_valid !== 1'b0) begin failures++; $display("[TB] FAIL byp_early got %b want 0", m_axis_bypass_valid); end
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checks++; if (m_axis_bypass_valid !== 1'b1) begin failures++; $display("[TB] FAIL byp_valid got %b want 1", m_axis_bypass_valid); end
    checks++; if (m_axis_bypass_data !== 32'h0000_0010) begin failures++; $display("[TB] FAIL byp_data got %h want 00000010", m_axis_bypass_data); end
    checks++; if (m_axis_cal_valid !== 1'b0) begin failures++; $display("[TB] FAIL byp_cal_idle got %b want 0", m_axis_cal_valid); end
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (m_axis_bypass_valid !== 1'b0) begin failures++; $display("[TB] FAIL byp_pulse_end got %b want 0", m_axis_bypass_valid); end
  endtask

  task automatic test_cal_path();
    logic [31:0] exp_words [3];
    exp_words[0] = 32'hA;
    exp_words[1] = 32'hB;
    exp_words[2] = 32'hC;
    apply_stimulus(1'b1, 32'hA, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'hB, 1'b1, 1'b0);
    checks++; if (m_axis_cal_valid !== 1'b1 || m_axis_cal_data !== exp_words[0]) begin failures++; $display("[TB] FAIL cal_word0 got v=%b %h want v=1 %h", m_axis_cal_valid, m_axis_cal_data, exp_words[0]); end
    apply_stimulus(1'b1, 32'hC, 1'b1, 1'b0);
    checks++; if (m_axis_cal_valid !== 1'b1 || m_axis_cal_data !== exp_words[1]) begin failures++; $display("[TB] FAIL cal_word1 got v=%b %h want v=1 %h", m_axis_cal_valid, m_axis_cal_data, exp_words[1]); end
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (m_axis_cal_valid !== 1'b1 || m_axis_cal_data !== exp_words[2]) begin failures++; $display("[TB] FAIL cal_word2 got v=%b %h want v=1 %h", m_axis_cal_valid, m_axis_cal_data, exp_words[2]); end
    checks++; if (m_axis_bypass_valid !== 1'b0) begin failures++; $display("[TB] FAIL cal_byp_idle got %b want 0", m_axis_bypass_valid); end
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (m_axis_cal_valid !== 1'b0) begin failures++; $display("[TB] FAIL cal_empty got %b want 0", m_axis_cal_valid); end
  endtask

  task automatic test_overflow();
    m_axis_cal_ready = 1'b0;
    apply_stimulus(1'b1, 32'h20, 1'b0, 1'b0);
    for (int i = 1; i < 6; i++) begin
      apply_stimulus(1'b1, 32'h20 + 32'(i), 1'b1, 1'b0);
    end
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (drop_cnt !== 16'd2) begin failures++; $display("[TB] FAIL ovf_drop_cnt got %0d want 2", drop_cnt); end
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (m_axis_cal_data !== 32'h20) begin failures++; $display("[TB] FAIL ovf_hold_data got %h want 00000020", m_axis_cal_data); end
    m_axis_cal_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_axis_cal_valid !== 1'b1 || m_axis_cal_data !== 32'h20 + 32'(i)) begin failures++; $display("[TB] FAIL ovf_drain%0d got v=%b %h want v=1 %h", i, m_axis_cal_valid, m_axis_cal_data, 32'h20 + 32'(i)); end
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    end
    checks++; if (m_axis_cal_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_empty got %b want 0", m_axis_cal_valid); end
  endtask

  task automatic test_full_pop();
    m_axis_cal_ready = 1'b0;
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      apply_stimulus(1'b1, 32'h40 + 32'(i), 1'b1, 1'b0);
    end
    checks++; if (m_axis_cal_data !== 32'h40) begin failures++; $display("[TB] FAIL full_head got %h want 00000040", m_axis_cal_data); end
    m_axis_cal_ready = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checks++; if (drop_cnt !== 16'd2) begin failures++; $display("[TB] FAIL full_pop_drop_cnt got %0d want 2", drop_cnt); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (m_axis_cal_valid !== 1'b1 || m_axis_cal_data !== 32'h40 + 32'(i)) begin failures++; $display("[TB] FAIL full_pop_drain%0d got v=%b %h want v=1 %h", i, m_axis_cal_valid, m_axis_cal_data, 32'h40 + 32'(i)); end
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    end
    checks++; if (m_axis_cal_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_pop_empty got %b want 0", m_axis_cal_valid); end
  endtask

  task automatic test_misalign();
    checks++; if (err_align !== 1'b0) begin failures++; $display("[TB] FAIL misalign_pre got %b want 0", err_align); end
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checks++; if (err_align !== 1'b1) begin failures++; $display("[TB] FAIL misalign_set got %b want 1", err_align); end
    checks++; if (m_axis_bypass_valid !== 1'b0 || m_axis_cal_valid !== 1'b0) begin failures++; $display("[TB] FAIL misalign_no_out got byp=%b cal=%b want 0 0", m_axis_bypass_valid, m_axis_cal_valid); end
    apply_stimulus(1'b1, 32'h77, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (m_axis_bypass_valid !== 1'b0 || m_axis_cal_valid !== 1'b0) begin failures++; $display("[TB] FAIL orphan_no_out got byp=%b cal=%b want 0 0", m_axis_bypass_valid, m_axis_cal_valid); end
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (err_align !== 1'b1) begin failures++; $display("[TB] FAIL misalign_sticky got %b want 1", err_align); end
    checks++; if (drop_cnt !== 16'd2) begin failures++; $display("[TB] FAIL misalign_drop_cnt got %0d want 2", drop_cnt); end
  endtask

  task automatic test_mid_reset();
    m_axis_bypass_ready = 1'b0;
    apply_stimulus(1'b1, 32'h61, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h62, 1'b1, 1'b1);
    apply_stimulus(1'b1, 32'h63, 1'b1, 1'b1);
    checks++; if (m_axis_bypass_valid !== 1'b1 || m_axis_bypass_data !== 32'h61) begin failures++; $display("[TB] FAIL mid_pre got v=%b %h want v=1 00000061", m_axis_bypass_valid, m_axis_bypass_data); end
    s_axis_valid       = 1'b0;
    s_axis_check_valid = 1'b0;
    rstn = 1'b0;
    #1;
    checks++; if (m_axis_bypass_valid !== 1'b0 || m_axis_bypass_data !== 32'h0) begin failures++; $display("[TB] FAIL mid_rst_byp got v=%b %h want v=0 0", m_axis_bypass_valid, m_axis_bypass_data); end
    checks++; if (drop_cnt !== 16'd0 || err_align !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_status got drop=%0d err=%b want 0 0", drop_cnt, err_align); end
    #1;
    rstn = 1'b1;
    m_axis_bypass_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_axis_bypass_valid !== 1'b0 || m_axis_cal_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_stale%0d got byp=%b cal=%b want 0 0", i, m_axis_bypass_valid, m_axis_cal_valid); end
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    end
    checks++; if (err_align !== 1'b0) begin failures++; $display("[TB] FAIL mid_err_clear got %b want 0", err_align); end
  endtask

  initial begin
    rstn                = 1'b0;
    s_axis_valid        = 1'b0;
    s_axis_pifo_info    = 32'h0;
    s_axis_check_valid  = 1'b0;
    s_axis_bypass_en    = 1'b0;
    m_axis_bypass_ready = 1'b0;
    m_axis_cal_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rstn = 1'b1;
    @(posedge clk);
    #1;
    test_bypass_path();
    test_cal_path();
    test_overflow();
    test_full_pop();
    test_misalign();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
